// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS memory-access stage with request/ready data port
module mem_access_stage #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemWriteIn,
   input  logic              MemReadIn,
   input  logic              MemToRegIn,
   input  logic              RegWriteIn,
   input  logic [DATA_W-1:0] ALUResultIn,
   input  logic [DATA_W-1:0] WriteDataIn,
   input  logic [DEST_W-1:0] DestinationRegIn,
   output logic              MemReq,
   output logic              MemWe,
   output logic [DATA_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemReady,
   input  logic [DATA_W-1:0] MemRData,
   output logic              Stall,
   output logic              RegWriteOut,
   output logic              MemToRegOut,
   output logic [DATA_W-1:0] ReadDataOut,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [DEST_W-1:0] DestinationRegOut,
   output logic              AlignErr,
   output logic [CNT_W-1:0]  StallCount
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                hold_rw_q, hold_rw_d;
   logic                hold_mtr_q, hold_mtr_d;
   logic [DEST_W-1:0]   hold_dest_q, hold_dest_d;
   logic                rw_out_q, rw_out_d;
   logic                mtr_out_q, mtr_out_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   alu_out_q, alu_out_d;
   logic [DEST_W-1:0]   dest_out_q, dest_out_d;
   logic                aerr_q, aerr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                stall_c;
   logic                access;
   logic                misaligned;

   assign access     = MemReadIn | MemWriteIn;
   assign misaligned = |ALUResultIn[1:0];

   // Next-state, MEM/WB capture and stall decision; a store wins over a load when both are set
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      hold_rw_d   = hold_rw_q;
      hold_mtr_d  = hold_mtr_q;
      hold_dest_d = hold_dest_q;
      rw_out_d    = rw_out_q;
      mtr_out_d   = mtr_out_q;
      rdata_d     = rdata_q;
      alu_out_d   = alu_out_q;
      dest_out_d  = dest_out_q;
      aerr_d      = 1'b0;
      stall_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!access) begin
               rw_out_d   = RegWriteIn;
               mtr_out_d  = MemToRegIn;
               alu_out_d  = ALUResultIn;
               dest_out_d = DestinationRegIn;
               rdata_d    = '0;
            end else if (misaligned) begin
               aerr_d     = 1'b1;
               rw_out_d   = 1'b0;
               mtr_out_d  = 1'b0;
               alu_out_d  = ALUResultIn;
               dest_out_d = DestinationRegIn;
               rdata_d    = '0;
            end else begin
               stall_c     = 1'b1;
               rw_out_d    = 1'b0;
               mtr_out_d   = 1'b0;
               req_d       = 1'b1;
               we_d        = MemWriteIn;
               addr_d      = ALUResultIn;
               wdata_d     = WriteDataIn;
               hold_rw_d   = RegWriteIn;
               hold_mtr_d  = MemToRegIn;
               hold_dest_d = DestinationRegIn;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!MemReady) begin
               stall_c   = 1'b1;
               rw_out_d  = 1'b0;
               mtr_out_d = 1'b0;
            end else begin
               req_d      = 1'b0;
               state_d    = S_IDLE;
               rw_out_d   = hold_rw_q;
               mtr_out_d  = hold_mtr_q;
               alu_out_d  = addr_q;
               dest_out_d = hold_dest_q;
               rdata_d    = we_q ? '0 : MemRData;
            end
         end
         default: state_d = S_IDLE;
      endcase
      cnt_d = (stall_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // State, request, holding and MEM/WB registers; reset abandons any in-flight request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         hold_rw_q   <= 1'b0;
         hold_mtr_q  <= 1'b0;
         hold_dest_q <= '0;
         rw_out_q    <= 1'b0;
         mtr_out_q   <= 1'b0;
         rdata_q     <= '0;
         alu_out_q   <= '0;
         dest_out_q  <= '0;
         aerr_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         hold_rw_q   <= hold_rw_d;
         hold_mtr_q  <= hold_mtr_d;
         hold_dest_q <= hold_dest_d;
         rw_out_q    <= rw_out_d;
         mtr_out_q   <= mtr_out_d;
         rdata_q     <= rdata_d;
         alu_out_q   <= alu_out_d;
         dest_out_q  <= dest_out_d;
         aerr_q      <= aerr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign Stall             = rst & stall_c;
   assign MemReq            = req_q;
   assign MemWe             = we_q;
   assign MemAddr           = addr_q;
   assign MemWData          = wdata_q;
   assign RegWriteOut       = rw_out_q;
   assign MemToRegOut       = mtr_out_q;
   assign ReadDataOut       = rdata_q;
   assign ALUResultOut      = alu_out_q;
   assign DestinationRegOut = dest_out_q;
   assign AlignErr          = aerr_q;
   assign StallCount        = cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic        MemWriteIn, MemReadIn, MemToRegIn, RegWriteIn;
   logic [31:0] ALUResultIn, WriteDataIn;
   logic [4:0]  DestinationRegIn;
   logic        MemReq, MemWe;
   logic [31:0] MemAddr, MemWData;
   logic        MemReady;
   logic [31:0] MemRData;
   logic        Stall;
   logic        RegWriteOut, MemToRegOut;
   logic [31:0] ReadDataOut, ALUResultOut;
   logic [4:0]  DestinationRegOut;
   logic        AlignErr;
   logic [15:0] StallCount;

   mem_access_stage #(.DATA_W(32), .DEST_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
      .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn),
      .ALUResultIn(ALUResultIn), .WriteDataIn(WriteDataIn),
      .DestinationRegIn(DestinationRegIn),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemReady(MemReady), .MemRData(MemRData), .Stall(Stall),
      .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
      .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
      .DestinationRegOut(DestinationRegOut), .AlignErr(AlignErr),
      .StallCount(StallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd, wr, mtr, rw;
      logic [31:0] alu, wd;
      logic [4:0]  dest;
      bit          ready;
      logic [31:0] rdata;
   } in_t;

   typedef struct {
      in_t         in;
      bit          e_aerr, e_rw, e_mtr;
      logic [31:0] e_alu;
      logic [4:0]  e_dest;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference: one optional outstanding request plus the MEM/WB view
   bit          m_pend, m_we;
   logic [31:0] m_addr, m_wdata;
   bit          m_hrw, m_hmtr;
   logic [4:0]  m_hdest;
   bit          o_rw, o_mtr, o_aerr;
   logic [31:0] o_rdata, o_alu;
   logic [4:0]  o_dest;
   int          m_cnt;
   bit          last_stall;

   vec_t tbl [6];

   function automatic in_t mk(bit rd, bit wr, bit mtr, bit rw, logic [31:0] alu,
                              logic [31:0] wd, logic [4:0] dest, bit ready, logic [31:0] rdata);
      in_t v;
      v.rd = rd; v.wr = wr; v.mtr = mtr; v.rw = rw; v.alu = alu; v.wd = wd;
      v.dest = dest; v.ready = ready; v.rdata = rdata;
      return v;
   endfunction

   function automatic vec_t mkv(in_t v, bit aerr, bit rw, bit mtr, logic [31:0] alu, logic [4:0] dest);
      vec_t t;
      t.in = v; t.e_aerr = aerr; t.e_rw = rw; t.e_mtr = mtr; t.e_alu = alu; t.e_dest = dest;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_hrw = 0; m_hmtr = 0; m_hdest = 0;
      o_rw = 0; o_mtr = 0; o_aerr = 0; o_rdata = 0; o_alu = 0; o_dest = 0;
      m_cnt = 0; last_stall = 0;
   endtask

   task automatic model_step(input in_t v, output bit stall);
      bit acc;
      acc = v.rd | v.wr;
      stall = 0;
      o_aerr = 0;
      if (!m_pend) begin
         if (!acc) begin
            o_rw = v.rw; o_mtr = v.mtr; o_alu = v.alu; o_dest = v.dest; o_rdata = 0;
         end else if ((v.alu % 4) != 0) begin
            o_aerr = 1; o_rw = 0; o_mtr = 0; o_alu = v.alu; o_dest = v.dest; o_rdata = 0;
         end else begin
            stall = 1; o_rw = 0; o_mtr = 0;
            m_pend = 1; m_we = v.wr; m_addr = v.alu; m_wdata = v.wd;
            m_hrw = v.rw; m_hmtr = v.mtr; m_hdest = v.dest;
         end
      end else if (!v.ready) begin
         stall = 1; o_rw = 0; o_mtr = 0;
      end else begin
         o_rw = m_hrw; o_mtr = m_hmtr; o_alu = m_addr; o_dest = m_hdest;
         o_rdata = m_we ? 32'h0 : v.rdata;
         m_pend = 0;
      end
      if (stall && m_cnt < 65535) m_cnt++;
   endtask

   task automatic chk_outputs();
      chk("MemReq", 32'(MemReq), 32'(m_pend));
      if (m_pend) begin
         chk("MemWe", 32'(MemWe), 32'(m_we));
         chk("MemAddr", MemAddr, m_addr);
         chk("MemWData", MemWData, m_wdata);
      end
      chk("RegWriteOut", 32'(RegWriteOut), 32'(o_rw));
      chk("MemToRegOut", 32'(MemToRegOut), 32'(o_mtr));
      chk("ReadDataOut", ReadDataOut, o_rdata);
      chk("ALUResultOut", ALUResultOut, o_alu);
      chk("DestinationRegOut", 32'(DestinationRegOut), 32'(o_dest));
      chk("AlignErr", 32'(AlignErr), 32'(o_aerr));
      chk("StallCount", 32'(StallCount), 32'(m_cnt));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_Stall"}, 32'(Stall), 32'h0);
      chk({tag, "_MemReq"}, 32'(MemReq), 32'h0);
      chk({tag, "_MemWe"}, 32'(MemWe), 32'h0);
      chk({tag, "_MemAddr"}, MemAddr, 32'h0);
      chk({tag, "_MemWData"}, MemWData, 32'h0);
      chk({tag, "_RegWriteOut"}, 32'(RegWriteOut), 32'h0);
      chk({tag, "_MemToRegOut"}, 32'(MemToRegOut), 32'h0);
      chk({tag, "_ReadDataOut"}, ReadDataOut, 32'h0);
      chk({tag, "_ALUResultOut"}, ALUResultOut, 32'h0);
      chk({tag, "_DestOut"}, 32'(DestinationRegOut), 32'h0);
      chk({tag, "_AlignErr"}, 32'(AlignErr), 32'h0);
      chk({tag, "_StallCount"}, 32'(StallCount), 32'h0);
   endtask

   task automatic drive(input in_t v);
      MemReadIn = v.rd; MemWriteIn = v.wr; MemToRegIn = v.mtr; RegWriteIn = v.rw;
      ALUResultIn = v.alu; WriteDataIn = v.wd; DestinationRegIn = v.dest;
      MemReady = v.ready; MemRData = v.rdata;
   endtask

   // One pipeline cycle: drive after the falling edge, check Stall, then registered outputs
   task automatic step(input in_t v, input bit full);
      bit es;
      @(negedge clk);
      drive(v);
      #1;
      model_step(v, es);
      last_stall = es;
      if (full) chk("Stall", 32'(Stall), 32'(es));
      @(posedge clk);
      #1;
      if (full) chk_outputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      in_t idle, s, cur;

      tbl[0] = mkv(mk(0,0,0,1,32'h7,32'h0,5'd3,0,32'h0),            0,1,0,32'h7,5'd3);
      tbl[1] = mkv(mk(1,0,1,1,32'h42,32'h0,5'd9,1,32'h1111),        1,0,0,32'h42,5'd9);
      tbl[2] = mkv(mk(0,0,0,0,32'h10,32'h55,5'd0,1,32'h0),          0,0,0,32'h10,5'd0);
      tbl[3] = mkv(mk(0,1,0,0,32'h81,32'hCAFE,5'd2,0,32'h0),        1,0,0,32'h81,5'd2);
      tbl[4] = mkv(mk(1,1,1,1,32'h3,32'h9,5'd31,0,32'h0),           1,0,0,32'h3,5'd31);
      tbl[5] = mkv(mk(0,0,1,1,32'hFFFFFFFC,32'h0,5'd17,1,32'h0),    0,1,1,32'hFFFFFFFC,5'd17);

      idle = mk(0,0,0,0,32'h0,32'h0,5'd0,0,32'h0);

      // reset with an aligned load on the inputs: Stall must stay low
      rst = 1'b0;
      drive(mk(1,0,1,1,32'h40,32'h0,5'd5,1,32'h0));
      #2;
      chk_reset_vals("rst0");
      @(negedge clk);
      drive(idle);
      MemReady = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // stale MemReady right after reset is ignored
      s = idle; s.ready = 1; s.rdata = 32'hBAD0BAD0;
      step(s, 1);

      foreach (tbl[i]) begin
         step(tbl[i].in, 1);
         chk($sformatf("tbl%0d_Stall", i), 32'(last_stall), 32'h0);
         chk($sformatf("tbl%0d_AlignErr", i), 32'(AlignErr), 32'(tbl[i].e_aerr));
         chk($sformatf("tbl%0d_RegWriteOut", i), 32'(RegWriteOut), 32'(tbl[i].e_rw));
         chk($sformatf("tbl%0d_MemToRegOut", i), 32'(MemToRegOut), 32'(tbl[i].e_mtr));
         chk($sformatf("tbl%0d_ALUResultOut", i), ALUResultOut, tbl[i].e_alu);
         chk($sformatf("tbl%0d_DestOut", i), 32'(DestinationRegOut), 32'(tbl[i].e_dest));
         chk($sformatf("tbl%0d_ReadDataOut", i), ReadDataOut, 32'h0);
         chk($sformatf("tbl%0d_MemReq", i), 32'(MemReq), 32'h0);
      end
      step(idle, 1);
      chk("align_pulse_drop", 32'(AlignErr), 32'h0);

      // zero-wait load
      s = mk(1,0,1,1,32'h40,32'h0,5'd5,0,32'h0);
      step(s, 1);
      chk("zw_req", 32'(MemReq), 32'h1);
      chk("zw_addr", MemAddr, 32'h40);
      chk("zw_we", 32'(MemWe), 32'h0);
      chk("zw_bubble_rw", 32'(RegWriteOut), 32'h0);
      s.ready = 1; s.rdata = 32'hDEADBEEF;
      step(s, 1);
      chk("zw_ready_stall", 32'(last_stall), 32'h0);
      chk("zw_rw", 32'(RegWriteOut), 32'h1);
      chk("zw_rdata", ReadDataOut, 32'hDEADBEEF);
      chk("zw_dest", 32'(DestinationRegOut), 32'd5);
      chk("zw_req_fall", 32'(MemReq), 32'h0);
      chk("zw_stallcnt", 32'(StallCount), 32'd1);

      // ALU op right after the load
      step(mk(0,0,0,1,32'h7,32'h0,5'd3,0,32'h0), 1);
      chk("alu_rw", 32'(RegWriteOut), 32'h1);
      chk("alu_res", ALUResultOut, 32'h7);
      chk("alu_dest", 32'(DestinationRegOut), 32'd3);

      // store with three wait cycles
      s = mk(0,1,0,0,32'h80,32'h12345678,5'd4,0,32'h0);
      step(s, 1);
      for (int i = 0; i < 4; i++) begin
         chk("ws_req", 32'(MemReq), 32'h1);
         chk("ws_addr", MemAddr, 32'h80);
         chk("ws_wdata", MemWData, 32'h12345678);
         s.ready = (i == 3); s.rdata = 32'hA5A5A5A5;
         step(s, 1);
      end
      chk("ws_req_fall", 32'(MemReq), 32'h0);
      chk("ws_rw", 32'(RegWriteOut), 32'h0);
      chk("ws_rdata", ReadDataOut, 32'h0);
      chk("ws_stallcnt", 32'(StallCount), 32'd5);

      // read and write together behave as a store
      s = mk(1,1,1,1,32'h200,32'h77,5'd8,0,32'h0);
      step(s, 1);
      chk("both_we", 32'(MemWe), 32'h1);
      s.ready = 1; s.rdata = 32'hFFFF0000;
      step(s, 1);
      chk("both_rdata", ReadDataOut, 32'h0);
      chk("both_stallcnt", 32'(StallCount), 32'd6);

      // reset while a load is outstanding
      s = mk(1,0,1,1,32'h100,32'h0,5'd6,0,32'h0);
      step(s, 1);
      step(s, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_vals("midbusy");
      drive(idle);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      s = idle; s.ready = 1; s.rdata = 32'h12121212;
      step(s, 1);
      chk("midbusy_req", 32'(MemReq), 32'h0);
      chk("midbusy_rw", 32'(RegWriteOut), 32'h0);
      chk("midbusy_rdata", ReadDataOut, 32'h0);

      // randomized traffic; inputs hold while the stage stalls
      cur = idle;
      for (int n = 0; n < 400; n++) begin
         if (!last_stall) begin
            case ($urandom_range(0, 3))
               0: begin cur.rd = 0; cur.wr = 0; end
               1: begin cur.rd = 1; cur.wr = 0; end
               2: begin cur.rd = 0; cur.wr = 1; end
               default: begin cur.rd = 1; cur.wr = 1; end
            endcase
            cur.mtr = 1'($urandom_range(0, 1));
            cur.rw = 1'($urandom_range(0, 1));
            cur.alu = $urandom;
            if ($urandom_range(0, 3) != 0) cur.alu = cur.alu & 32'hFFFFFFFC;
            cur.wd = $urandom;
            cur.dest = 5'($urandom_range(0, 31));
         end
         cur.ready = ($urandom_range(0, 2) == 0);
         cur.rdata = $urandom;
         step(cur, 1);
      end

      // saturation of the stall counter under one very long wait
      @(negedge clk);
      drive(idle);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      s = mk(1,0,1,1,32'h300,32'h0,5'd7,0,32'h0);
      step(s, 1);
      for (int n = 0; n < 65540; n++) step(s, 0);
      chk("sat_cnt", 32'(StallCount), 32'h0000FFFF);
      chk("sat_req", 32'(MemReq), 32'h1);
      s.ready = 1; s.rdata = 32'h31415926;
      step(s, 1);
      s = mk(0,1,0,0,32'h304,32'h1,5'd0,0,32'h0);
      step(s, 1);
      s.ready = 1;
      step(s, 1);
      chk("sat_nowrap", 32'(StallCount), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
